wb_arbiter: RTL



---
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_arbiter.sv | 99 +++++++++
 2 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback port bundle: pipeline result, long-latency handshake and
// register-file write port. The arbiter takes the slave side.
interface wb_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_is_load;
  logic [2:0]      pipe_funct3;

  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;

  logic [4:0]      rd;
  logic [XLEN-1:0] writedata;
  logic            reg_write;
  logic [CW-1:0]   fifo_count;

  modport master (
    output pipe_valid, pipe_rd, pipe_data, pipe_is_load, pipe_funct3,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready,
    input  rd, writedata, reg_write, fifo_count
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data, pipe_is_load, pipe_funct3,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready,
    output rd, writedata, reg_write, fifo_count
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback merger: pipeline results win the register-file port, long-latency
// results queue in an in-order FIFO and drain into idle slots.
module wb_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            pipe_live;
  logic            fifo_empty;
  logic            lu_xfer;
  logic            bypass;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] pipe_wdata;

  always_comb begin
    pipe_wdata = bus.pipe_data;
    if (bus.pipe_is_load) begin
      case (bus.pipe_funct3)
        3'b000:  pipe_wdata = {{(XLEN-8){bus.pipe_data[7]}},   bus.pipe_data[7:0]};
        3'b001:  pipe_wdata = {{(XLEN-16){bus.pipe_data[15]}}, bus.pipe_data[15:0]};
        3'b010:  pipe_wdata = {{(XLEN-32){bus.pipe_data[31]}}, bus.pipe_data[31:0]};
        3'b100:  pipe_wdata = {{(XLEN-8){1'b0}},  bus.pipe_data[7:0]};
        3'b101:  pipe_wdata = {{(XLEN-16){1'b0}}, bus.pipe_data[15:0]};
        3'b110:  pipe_wdata = {{(XLEN-32){1'b0}}, bus.pipe_data[31:0]};
        default: pipe_wdata = bus.pipe_data;
      endcase
    end
  end

  // Ready depends only on the registered count, so a full FIFO never
  // accepts even when it pops in the same cycle.
  assign bus.lu_ready = (count < CW'(DEPTH));

  assign pipe_live  = bus.pipe_valid && (bus.pipe_rd != 5'd0);
  assign fifo_empty = (count == '0);
  assign lu_xfer    = bus.lu_valid && bus.lu_ready;
  assign pop        = !pipe_live && !fifo_empty;
  assign bypass     = !pipe_live && fifo_empty && lu_xfer && (bus.lu_rd != 5'd0);
  // Results for x0 complete the handshake but are never stored.
  assign push       = lu_xfer && (bus.lu_rd != 5'd0) && !bypass;

  assign bus.fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.lu_rd;
      fifo_data[wr_ptr] <= bus.lu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rd        <= '0;
      bus.writedata <= '0;
      bus.reg_write <= 1'b0;
    end else begin
      bus.reg_write <= pipe_live || pop || bypass;
      if (pipe_live) begin
        bus.rd        <= bus.pipe_rd;
        bus.writedata <= pipe_wdata;
      end else if (pop) begin
        bus.rd        <= fifo_rd[rd_ptr];
        bus.writedata <= fifo_data[rd_ptr];
      end else if (bypass) begin
        bus.rd        <= bus.lu_rd;
        bus.writedata <= bus.lu_data;
      end
    end
  end
endmodule
